// File: rtl/chroni_arb_pkg.sv
// Shared types and defaults for the chroni memory read-port arbiter.
package chroni_arb_pkg;

   typedef enum logic [1:0] {
      ArbIdle = 2'd0,
      ArbWait = 2'd1,
      ArbDone = 2'd2
   } arb_state_e;

   typedef logic [1:0] req_id_t;

   localparam req_id_t     VideoReqId = 2'd0;
   localparam int unsigned DefAddrW   = 13;
   localparam int unsigned DefDataW   = 8;
   localparam int unsigned TmoCntW    = 8;

   // Round-robin successor among requesters 1..num_req-1; never yields 0.
   function automatic req_id_t rr_next(req_id_t id, int unsigned num_req);
      if (id == req_id_t'(num_req - 1)) begin
         return req_id_t'(1);
      end
      return id + req_id_t'(1);
   endfunction

endpackage

// File: rtl/chroni_rr_pick.sv
// Combinational circular search over requesters 1..NumReq-1, starting at rr_ptr_i.
module chroni_rr_pick
   import chroni_arb_pkg::*;
#(
   parameter int unsigned  NumReq = 3,
   localparam int unsigned PtrW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:1] req_i,
   input  logic [PtrW-1:0]   rr_ptr_i,
   output logic              valid_o,
   output req_id_t           idx_o
);

   logic [PtrW:0] cand;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int unsigned k = 0; k < NumReq - 1; k++) begin
         cand = {1'b0, rr_ptr_i} + (PtrW + 1)'(k);
         // Wrap past the last requester back to 1, skipping the video slot.
         if (cand > (PtrW + 1)'(NumReq - 1)) begin
            cand = cand - (PtrW + 1)'(NumReq - 1);
         end
         if (!valid_o && req_i[cand[PtrW-1:0]]) begin
            valid_o = 1'b1;
            idx_o   = req_id_t'(cand);
         end
      end
   end

endmodule

// File: rtl/chroni_mem_arbiter.sv
// Memory read-port arbiter: requester 0 (video) fixed priority, others round-robin.
// Optional WAIT timeout enabled by defining CHRONI_ARB_TIMEOUT_EN.
module chroni_mem_arbiter
   import chroni_arb_pkg::*;
#(
   parameter int unsigned NumReq  = 3,
   parameter int unsigned AddrW   = DefAddrW,
   parameter int unsigned DataW   = DefDataW,
   parameter int unsigned Timeout = 255
) (
   input  logic                    sys_clk_i,
   input  logic                    reset_ni,
   input  logic [NumReq-1:0]       req_i,
   input  logic [NumReq*AddrW-1:0] req_addr_i,
   output logic [NumReq-1:0]       ack_o,
   output logic [DataW-1:0]        rd_data_o,
   output logic [AddrW-1:0]        mem_addr_o,
   output logic                    mem_rd_req_o,
   input  logic                    mem_rd_ack_i,
   input  logic [DataW-1:0]        mem_data_in_i,
   output logic [1:0]              grant_id_o,
   output logic                    arb_err_o
);

   localparam int unsigned PtrW = $clog2(NumReq);

   if (NumReq < 2 || NumReq > 4) begin : g_bad_num_req
      $error("chroni_mem_arbiter: NumReq must be in 2..4");
   end
   if (Timeout < 1 || Timeout > 255) begin : g_bad_timeout
      $error("chroni_mem_arbiter: Timeout must fit the 8-bit wait counter");
   end

   arb_state_e        state_q, state_d;
   req_id_t           grant_q, grant_d;
   logic [AddrW-1:0]  mem_addr_q, mem_addr_d;
   logic              mem_rd_req_q, mem_rd_req_d;
   logic [DataW-1:0]  rd_data_q, rd_data_d;
   logic [NumReq-1:0] ack_q, ack_d;
   logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
`ifdef CHRONI_ARB_TIMEOUT_EN
   logic [TmoCntW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic               arb_err_q, arb_err_d;
`endif

   logic [AddrW-1:0] addr_slice [NumReq];
   logic             pick_valid;
   req_id_t          pick_idx;
   req_id_t          win;

   for (genvar i = 0; i < NumReq; i++) begin : g_addr_slice
      assign addr_slice[i] = req_addr_i[i*AddrW +: AddrW];
   end

   chroni_rr_pick #(
      .NumReq (NumReq)
   ) u_rr_pick (
      .req_i    (req_i[NumReq-1:1]),
      .rr_ptr_i (rr_ptr_q),
      .valid_o  (pick_valid),
      .idx_o    (pick_idx)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      mem_addr_d   = mem_addr_q;
      mem_rd_req_d = mem_rd_req_q;
      rd_data_d    = rd_data_q;
      ack_d        = '0;
      rr_ptr_d     = rr_ptr_q;
      win          = req_i[VideoReqId] ? VideoReqId : pick_idx;
`ifdef CHRONI_ARB_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      arb_err_d    = arb_err_q;
`endif

      case (state_q)
         ArbIdle: begin
            if (req_i[VideoReqId] || pick_valid) begin
               grant_d      = win;
               mem_addr_d   = addr_slice[win[PtrW-1:0]];
               mem_rd_req_d = 1'b1;
               state_d      = ArbWait;
`ifdef CHRONI_ARB_TIMEOUT_EN
               tmo_cnt_d    = '0;
`endif
            end
         end
         ArbWait: begin
            if (mem_rd_ack_i) begin
               mem_rd_req_d                = 1'b0;
               rd_data_d                   = mem_data_in_i;
               ack_d[grant_q[PtrW-1:0]]    = 1'b1;
               state_d                     = ArbDone;
`ifdef CHRONI_ARB_TIMEOUT_EN
            end else if (tmo_cnt_q == TmoCntW'(Timeout - 1)) begin
               // Memory never answered: complete with all-ones so the requester unblocks.
               mem_rd_req_d                = 1'b0;
               rd_data_d                   = '1;
               ack_d[grant_q[PtrW-1:0]]    = 1'b1;
               arb_err_d                   = 1'b1;
               state_d                     = ArbDone;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TmoCntW'(1);
`endif
            end
         end
         ArbDone: begin
            // Gap cycle lets the served requester drop its req before re-arbitration.
            if (grant_q != VideoReqId) begin
               rr_ptr_d = PtrW'(rr_next(grant_q, NumReq));
            end
            state_d = ArbIdle;
         end
         default: begin
            state_d = ArbIdle;
         end
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= ArbIdle;
         grant_q      <= VideoReqId;
         mem_addr_q   <= '0;
         mem_rd_req_q <= 1'b0;
         rd_data_q    <= '0;
         ack_q        <= '0;
         rr_ptr_q     <= PtrW'(1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         mem_addr_q   <= mem_addr_d;
         mem_rd_req_q <= mem_rd_req_d;
         rd_data_q    <= rd_data_d;
         ack_q        <= ack_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

`ifdef CHRONI_ARB_TIMEOUT_EN
   always_ff @(posedge sys_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         tmo_cnt_q <= '0;
         arb_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         arb_err_q <= arb_err_d;
      end
   end

   assign arb_err_o = arb_err_q;
`else
   assign arb_err_o = 1'b0;
`endif

   assign ack_o        = ack_q;
   assign rd_data_o    = rd_data_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_rd_req_o = mem_rd_req_q;
   assign grant_id_o   = grant_q;

endmodule

// File: tb/tb_chroni_mem_arbiter.sv
// Directed and randomized bench for chroni_mem_arbiter with a request-level reference model.
module tb_chroni_mem_arbiter;

   localparam int NR = 3;
   localparam int AW = 13;
   localparam int DW = 8;

   logic             sys_clk = 1'b0;
   logic             reset_n;
   logic [NR-1:0]    req;
   logic [NR*AW-1:0] req_addr;
   logic [NR-1:0]    ack;
   logic [DW-1:0]    rd_data;
   logic [AW-1:0]    mem_addr;
   logic             mem_rd_req;
   logic             mem_rd_ack;
   logic [DW-1:0]    mem_data;
   logic [1:0]       grant_id;
   logic             arb_err;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   chroni_mem_arbiter #(
      .NumReq  (NR),
      .AddrW   (AW),
      .DataW   (DW),
      .Timeout (255)
   ) dut (
      .sys_clk_i     (sys_clk),
      .reset_ni      (reset_n),
      .req_i         (req),
      .req_addr_i    (req_addr),
      .ack_o         (ack),
      .rd_data_o     (rd_data),
      .mem_addr_o    (mem_addr),
      .mem_rd_req_o  (mem_rd_req),
      .mem_rd_ack_i  (mem_rd_ack),
      .mem_data_in_i (mem_data),
      .grant_id_o    (grant_id),
      .arb_err_o     (arb_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration rule: video first, else next low requester after the last one served.
   function automatic int exp_winner(input logic [NR-1:0] r, input int last);
      if (r[0]) return 0;
      for (int k = 1; k < NR; k++) begin
         int c;
         c = ((last - 1 + k) % (NR - 1)) + 1;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // Wait for a grant, answer it after lat cycles, check the completion, drop the request.
   task automatic serve(input int id, input logic [DW-1:0] d, input int lat);
      int n;
      n = 0;
      while (!mem_rd_req && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      chk("serve_grant_seen", mem_rd_req, 1);
      chk("serve_grant_id", grant_id, id);
      chk("serve_addr", mem_addr, req_addr[id*AW +: AW]);
      repeat (lat) @(negedge sys_clk);
      mem_rd_ack = 1'b1;
      mem_data   = d;
      @(negedge sys_clk);
      mem_rd_ack = 1'b0;
      chk("serve_ack", ack, 1 << id);
      chk("serve_rd_data", rd_data, d);
      req[id] = 1'b0;
   endtask

   initial begin
      int n;
      int model_last;
      int cur;
      int w;
      int lat;
      int stall;
      int just_dropped;
      bit txn;
      bit ack_driven;
      logic [DW-1:0] exp_data;
      logic [DW-1:0] model_rd;

      reset_n    = 1'b0;
      req        = '0;
      req_addr   = '0;
      mem_rd_ack = 1'b0;
      mem_data   = '0;

      // Reset values
      repeat (2) @(negedge sys_clk);
      chk("rst_ack", ack, 0);
      chk("rst_mem_rd_req", mem_rd_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_arb_err", arb_err, 0);
      reset_n = 1'b1;
      @(negedge sys_clk);

      // Single request, memory answers two cycles after mem_rd_req
      req_addr[1*AW +: AW] = 13'h0401;
      req[1] = 1'b1;
      @(negedge sys_clk);
      chk("single_mem_rd_req", mem_rd_req, 1);
      chk("single_mem_addr", mem_addr, 13'h0401);
      chk("single_grant", grant_id, 1);
      @(negedge sys_clk);
      mem_rd_ack = 1'b1;
      mem_data   = 8'h5A;
      @(negedge sys_clk);
      mem_rd_ack = 1'b0;
      chk("single_ack", ack, 3'b010);
      chk("single_rd_data", rd_data, 8'h5A);
      chk("single_req_drop", mem_rd_req, 0);
      req[1] = 1'b0;
      @(negedge sys_clk);
      chk("single_ack_once", ack, 0);
      chk("single_rd_hold", rd_data, 8'h5A);
      chk("single_grant_hold", grant_id, 1);

      // Collision between video and requester 2
      req_addr[0*AW +: AW] = 13'h1234;
      req_addr[2*AW +: AW] = 13'h0777;
      req[0] = 1'b1;
      req[2] = 1'b1;
      @(negedge sys_clk);
      chk("coll_grant0", grant_id, 0);
      chk("coll_addr0", mem_addr, 13'h1234);
      mem_rd_ack = 1'b1;
      mem_data   = 8'h11;
      @(negedge sys_clk);
      mem_rd_ack = 1'b0;
      chk("coll_ack0", ack, 3'b001);
      chk("coll_rd0", rd_data, 8'h11);
      req[0] = 1'b0;
      @(negedge sys_clk);
      chk("coll_done_gap", mem_rd_req, 0);
      chk("coll_done_noack", ack, 0);
      @(negedge sys_clk);
      chk("coll_grant2_req", mem_rd_req, 1);
      chk("coll_grant2", grant_id, 2);
      chk("coll_addr2", mem_addr, 13'h0777);
      mem_rd_ack = 1'b1;
      mem_data   = 8'h22;
      @(negedge sys_clk);
      mem_rd_ack = 1'b0;
      chk("coll_ack2", ack, 3'b100);
      req[2] = 1'b0;
      @(negedge sys_clk);

      // Round robin with requesters 1 and 2 re-requesting continuously
      req_addr[1*AW +: AW] = 13'h0111;
      req_addr[2*AW +: AW] = 13'h0222;
      req[1] = 1'b1;
      req[2] = 1'b1;
      for (int t = 0; t < 4; t++) begin
         serve((t % 2 == 0) ? 1 : 2, DW'(8'h30 + t), t % 3);
         @(negedge sys_clk);
         req[(t % 2 == 0) ? 1 : 2] = (t < 3);
      end
      req = '0;
      repeat (3) @(negedge sys_clk);

      // Reset in the middle of a WAIT
      req_addr[1*AW +: AW] = 13'h0ABC;
      req[1] = 1'b1;
      @(negedge sys_clk);
      chk("rstw_mem_rd_req", mem_rd_req, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rstw_abort_req", mem_rd_req, 0);
      chk("rstw_abort_ack", ack, 0);
      chk("rstw_abort_grant", grant_id, 0);
      req[1] = 1'b0;
      @(negedge sys_clk);
      reset_n = 1'b1;
      @(negedge sys_clk);
      mem_rd_ack = 1'b1;
      mem_data   = 8'h77;
      @(negedge sys_clk);
      mem_rd_ack = 1'b0;
      chk("rstw_late_ack", ack, 0);
      chk("rstw_late_rd", rd_data, 0);
      chk("rstw_idle", mem_rd_req, 0);

      // Requester drops req during WAIT
      req_addr[1*AW +: AW] = 13'h0155;
      req[1] = 1'b1;
      @(negedge sys_clk);
      chk("drop_mem_rd_req", mem_rd_req, 1);
      req[1] = 1'b0;
      @(negedge sys_clk);
      mem_rd_ack = 1'b1;
      mem_data   = 8'h3C;
      @(negedge sys_clk);
      mem_rd_ack = 1'b0;
      chk("drop_ack", ack, 3'b010);
      chk("drop_rd", rd_data, 8'h3C);
      @(negedge sys_clk);
      chk("drop_ack_once", ack, 0);
      req_addr[2*AW +: AW] = 13'h0222;
      req[2] = 1'b1;
      serve(2, 8'h4D, 1);
      repeat (2) @(negedge sys_clk);

`ifdef CHRONI_ARB_TIMEOUT_EN
      req_addr[1*AW +: AW] = 13'h0100;
      req[1] = 1'b1;
      @(negedge sys_clk);
      chk("tmo_mem_rd_req", mem_rd_req, 1);
      n = 0;
      while (ack == 0 && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      chk("tmo_wait_cycles", n, 255);
      chk("tmo_ack", ack, 3'b010);
      chk("tmo_rd_data", rd_data, 8'hFF);
      chk("tmo_arb_err", arb_err, 1);
      req[1] = 1'b0;
      repeat (4) @(negedge sys_clk);
      chk("tmo_arb_err_sticky", arb_err, 1);
      chk("tmo_idle", mem_rd_req, 0);
`else
      req_addr[1*AW +: AW] = 13'h0100;
      req[1] = 1'b1;
      @(negedge sys_clk);
      n = 0;
      while (ack == 0 && n < 300) begin
         @(negedge sys_clk);
         n++;
      end
      chk("notmo_no_ack", ack, 0);
      chk("notmo_still_waiting", mem_rd_req, 1);
      chk("notmo_arb_err", arb_err, 0);
      mem_rd_ack = 1'b1;
      mem_data   = 8'h99;
      @(negedge sys_clk);
      mem_rd_ack = 1'b0;
      chk("notmo_ack", ack, 3'b010);
      req[1] = 1'b0;
      @(negedge sys_clk);
`endif

      // Randomized traffic against the reference model, starting from a fresh reset
      reset_n = 1'b0;
      @(negedge sys_clk);
      reset_n = 1'b1;
      model_last = NR - 1;
      model_rd   = '0;
      txn        = 1'b0;
      ack_driven = 1'b0;
      cur        = 0;
      lat        = 0;
      stall      = 0;
      exp_data   = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge sys_clk);
         chk("rnd_ack", ack, ack_driven ? (1 << cur) : 0);
         just_dropped = -1;
         if (ack_driven) begin
            model_rd     = exp_data;
            req[cur]     = 1'b0;
            just_dropped = cur;
            if (cur != 0) model_last = cur;
            txn        = 1'b0;
            ack_driven = 1'b0;
            stall      = 0;
         end
         chk("rnd_rd_data", rd_data, model_rd);
         if (!txn && mem_rd_req) begin
            w = exp_winner(req, model_last);
            chk("rnd_grant", grant_id, w);
            if (w >= 0) begin
               chk("rnd_addr", mem_addr, req_addr[w*AW +: AW]);
               cur = w;
            end else begin
               cur = grant_id;
            end
            txn = 1'b1;
            lat = $urandom_range(0, 3);
         end
         chk("rnd_mem_rd_req", mem_rd_req, txn);
         mem_rd_ack = 1'b0;
         if (txn && !ack_driven) begin
            if (lat == 0) begin
               mem_rd_ack = 1'b1;
               mem_data   = DW'($urandom);
               exp_data   = mem_data;
               ack_driven = 1'b1;
            end else begin
               lat--;
            end
         end else if (!txn && $urandom_range(0, 7) == 0) begin
            mem_rd_ack = 1'b1;
            mem_data   = DW'($urandom);
         end
         for (int i = 0; i < NR; i++) begin
            if (!req[i] && i != just_dropped && $urandom_range(0, (i == 0) ? 5 : 2) == 0) begin
               req_addr[i*AW +: AW] = AW'($urandom);
               req[i] = 1'b1;
            end
         end
         if (req != 0 || txn) stall++;
         if (stall > 60) begin
            chk("rnd_progress", stall, 0);
            break;
         end
      end
      mem_rd_ack = 1'b0;
      chk("final_arb_err", arb_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chroni_mem_arbiter.md
Name: chroni_mem_arbiter

Overview:
- Arbitrates the single video/system memory read port (address out, data in, rd_req/rd_ack) between up to NUM_REQ read requesters.
- Requester 0 is the chroni text/font fetch engine and always has fixed top priority. Requesters 1..NUM_REQ-1 (CPU read path, future sprite/DMA fetch) share the remaining bandwidth round-robin.
- Sits between the requester-side rd_req/rd_ack handshakes and the memory port, on sys_clk.

Parameters:
NUM_REQ, 3, number of requesters (2..4); index 0 = video, fixed priority
ADDR_W, 13, address width
DATA_W, 8, data width
TIMEOUT, 255, max cycles waiting for mem_rd_ack (only used with CHRONI_ARB_TIMEOUT_EN)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester read request, level; held until its ack
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i = requester i, stable while req[i]
ack  out  NUM_REQ  per-requester one-cycle completion pulse
rd_data  out  DATA_W  registered read data; valid from ack cycle until next completion
mem_addr  out  ADDR_W  address to memory
mem_rd_req  out  1  memory read request, level
mem_rd_ack  in  1  memory completion, one-cycle pulse
mem_data_in  in  DATA_W  memory data, valid in mem_rd_ack cycle
grant_id  out  2  index of requester currently or last served
arb_err  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync release): state IDLE; ack=0, mem_rd_req=0, mem_addr=0, rd_data=0, grant_id=0, arb_err=0, rr_ptr=1. Reset mid-transaction aborts it immediately; no ack is issued.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req[0]=1, winner=0.
  - Else the first set req[i], i in 1..NUM_REQ-1, searching circularly from rd_ptr.
  - On a winner: grant_id<=winner, mem_addr<=slice, mem_rd_req<=1, go to WAIT. Request-to-mem_rd_req latency is 1 cycle.
  - No winner: stay in IDLE.
- WAIT, on mem_rd_ack: mem_rd_req<=0, rd_data<=mem_data_in, ack[grant_id]<=1 (one cycle), go to DONE. Any mem_rd_ack outside WAIT is ignored.
- DONE:
  - ack<=0.
  - If grant_id!=0, rr_ptr<=grant_id+1, wrapping to 1 after NUM_REQ-1.
  - Go to IDLE.
  - Requesters drop req in the cycle they see ack, so the DONE cycle guarantees no re-grant of a stale req.
- Minimum back-to-back cost: 3 cycles plus memory latency.
- Simultaneous requests: video always wins. Round-robin order holds among the others. A pending low-priority req waits while video re-requests continuously; this is accepted by design because video bandwidth is bounded per scanline.
- Requester dropping req before ack: the memory transaction still completes and ack is still pulsed. It is harmless and discarded.
- Address slices are sampled only in IDLE at grant. Later changes are ignored.
- rd_ptr arithmetic uses clog2(NUM_REQ) bits with explicit wrap. rr_ptr never equals 0.

Optional Feature:
- Macro: CHRONI_ARB_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT without mem_rd_ack: mem_rd_req<=0, rd_data<={DATA_W{1'b1}}, ack[grant_id] pulsed, arb_err<=1 (sticky until reset), go to DONE.
- Without the macro: no counter; WAIT waits indefinitely; arb_err tied 0.

Decomposition:
- Package chroni_arb_pkg holds:
  - state encodings ARB_IDLE=0, ARB_WAIT=1, ARB_DONE=2;
  - VIDEO_REQ_ID=0;
  - default widths (ADDR_W=13, DATA_W=8).
- One natural sub-module: chroni_rr_pick. It is combinational; it takes req[NUM_REQ-1:1] and rr_ptr and returns valid + index.
- The FSM, counters and registers remain in the top block.

Test Plan:
- Single request: req[1]=1, addr=13'h0401, memory acks 2 cycles after mem_rd_req with 8'h5A -> mem_addr=13'h0401 one cycle after req; ack[1] pulses once; rd_data=8'h5A; grant_id=1.
- Collision: req[0] and req[2] raised in the same cycle -> requester 0 served first; req[2] granted in the IDLE cycle after the DONE cycle; exactly two acks in order 0 then 2.
- Round robin: req[1] and req[2] held continuously for 4 transactions -> grant sequence 1,2,1,2.
- Reset mid-WAIT: reset_n low while mem_rd_req=1 -> mem_rd_req and ack 0 immediately; after release, state IDLE; a late mem_rd_ack produces no ack.
- Early drop: req[1] deasserted during WAIT -> ack[1] still pulses on mem_rd_ack; next grant proceeds normally.
- With CHRONI_ARB_TIMEOUT_EN, TIMEOUT=255, mem_rd_ack never asserted -> ack pulses after 255 WAIT cycles; rd_data=8'hFF; arb_err=1 and stays 1.
